// File: rtl/messbauer_pkg.sv
// Shared definitions for the Mossbauer velocity-sweep sequencer:
// state encoding, minimum channel period and default widths.
package messbauer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Shorter periods would leave no room for both phases of the channel strobe.
    localparam int MIN_PERIOD = 2;

    localparam int DEFAULT_PERIOD_WIDTH  = 16;
    localparam int DEFAULT_CHANNEL_WIDTH = 12;
    localparam int DEFAULT_SWEEP_WIDTH   = 16;

endpackage

// File: rtl/messbauer_sweep_sequencer_if.sv
// Command, configuration and status signals between the run controller
// and the sweep sequencer.
interface messbauer_sweep_sequencer_if
    import messbauer_pkg::*;
#(
    parameter int PERIOD_WIDTH  = DEFAULT_PERIOD_WIDTH,
    parameter int CHANNEL_WIDTH = DEFAULT_CHANNEL_WIDTH,
    parameter int SWEEP_WIDTH   = DEFAULT_SWEEP_WIDTH
) ();

    logic                     cmd_start;
    logic                     cmd_stop;
    logic [PERIOD_WIDTH-1:0]  cfg_period;
    logic [CHANNEL_WIDTH-1:0] cfg_channels;
    logic [SWEEP_WIDTH-1:0]   cfg_sweeps;

    logic                     channel;
    logic                     start;
    logic [CHANNEL_WIDTH-1:0] channel_index;
    logic [SWEEP_WIDTH-1:0]   sweep_count;
    logic                     busy;
    logic                     done;

    modport master (
        output cmd_start, cmd_stop, cfg_period, cfg_channels, cfg_sweeps,
        input  channel, start, channel_index, sweep_count, busy, done
    );

    modport slave (
        input  cmd_start, cmd_stop, cfg_period, cfg_channels, cfg_sweeps,
        output channel, start, channel_index, sweep_count, busy, done
    );

endinterface

// File: rtl/messbauer_channel_timer.sv
// Period counter for one velocity channel: produces the registered channel
// strobe and flags the last cycle of the channel.
module messbauer_channel_timer
    import messbauer_pkg::*;
#(
    parameter int PERIOD_WIDTH = DEFAULT_PERIOD_WIDTH
) (
    input  logic                    clk,
    input  logic                    areset_n,
    input  logic                    load,
    input  logic                    count,
    input  logic                    active_next,
    input  logic [PERIOD_WIDTH-1:0] period,
    output logic                    channel,
    output logic                    channel_end
);

    logic [PERIOD_WIDTH-1:0] pc;
    logic [PERIOD_WIDTH-1:0] pc_next;
    logic [PERIOD_WIDTH-1:0] half;

    always_comb begin
        half        = period >> 1;
        channel_end = count && (pc == period - 1'b1);
        pc_next     = pc;
        if (load) begin
            pc_next = '0;
        end else if (count) begin
            pc_next = channel_end ? '0 : pc + 1'b1;
        end
    end

    // The strobe is computed from the next count so it lines up with pc in the same cycle.
    always_ff @(posedge clk) begin
        if (!areset_n) begin
            pc      <= '0;
            channel <= 1'b0;
        end else begin
            pc      <= pc_next;
            channel <= active_next && (pc_next < half);
        end
    end

endmodule

// File: rtl/messbauer_sweep_sequencer.sv
// Run controller for the Mossbauer velocity sweep: latches the run
// configuration, steps channels and sweeps, and handles stop with drain.
module messbauer_sweep_sequencer
    import messbauer_pkg::*;
#(
    parameter int PERIOD_WIDTH  = DEFAULT_PERIOD_WIDTH,
    parameter int CHANNEL_WIDTH = DEFAULT_CHANNEL_WIDTH,
    parameter int SWEEP_WIDTH   = DEFAULT_SWEEP_WIDTH
) (
    input  logic                      clk,
    input  logic                      areset_n,
    messbauer_sweep_sequencer_if.slave bus
);

    state_t                   state;
    logic [PERIOD_WIDTH-1:0]  p_reg;
    logic [CHANNEL_WIDTH-1:0] n_reg;
    logic [SWEEP_WIDTH-1:0]   s_reg;
    logic [CHANNEL_WIDTH-1:0] ci;
    logic [SWEEP_WIDTH-1:0]   sc;
    logic                     start_reg;
    logic                     busy_reg;
    logic                     done_reg;

    logic                     load;
    logic                     counting;
    logic                     channel_end;
    logic                     last_channel;
    logic                     sweep_end;
    logic                     run_complete;
    logic                     finish;
    logic                     active_next;
    logic [PERIOD_WIDTH-1:0]  p_cfg;
    logic [CHANNEL_WIDTH-1:0] n_cfg;
    logic [PERIOD_WIDTH-1:0]  period_sel;
    logic [CHANNEL_WIDTH-1:0] ci_next;
    logic [SWEEP_WIDTH-1:0]   sc_inc;

    // Out-of-range configuration is clamped before it is latched.
    always_comb begin
        p_cfg = (bus.cfg_period < PERIOD_WIDTH'(MIN_PERIOD)) ?
                PERIOD_WIDTH'(MIN_PERIOD) : bus.cfg_period;
        n_cfg = (bus.cfg_channels == '0) ? CHANNEL_WIDTH'(1) : bus.cfg_channels;
    end

    always_comb begin
        load         = (state == IDLE) && bus.cmd_start;
        counting     = (state == RUN) || (state == DRAIN);
        period_sel   = load ? p_cfg : p_reg;
        last_channel = (ci == n_reg - 1'b1);
        sweep_end    = channel_end && last_channel;
        sc_inc       = sc + 1'b1;
        run_complete = sweep_end && (s_reg != '0) && (sc_inc == s_reg);
        finish       = ((state == RUN) && (run_complete || (bus.cmd_stop && channel_end)))
                     || ((state == DRAIN) && channel_end);
        active_next  = load || (counting && !finish);
        ci_next      = ci;
        if (load) begin
            ci_next = '0;
        end else if (channel_end) begin
            ci_next = last_channel ? '0 : ci + 1'b1;
        end
    end

    messbauer_channel_timer #(
        .PERIOD_WIDTH(PERIOD_WIDTH)
    ) timer (
        .clk         (clk),
        .areset_n    (areset_n),
        .load        (load),
        .count       (counting),
        .active_next (active_next),
        .period      (period_sel),
        .channel     (bus.channel),
        .channel_end (channel_end)
    );

    // A stop that lands on the last cycle of a channel ends the run straight from RUN.
    always_ff @(posedge clk) begin
        if (!areset_n) begin
            state     <= IDLE;
            p_reg     <= '0;
            n_reg     <= '0;
            s_reg     <= '0;
            ci        <= '0;
            sc        <= '0;
            start_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_start) begin
                        p_reg <= p_cfg;
                        n_reg <= n_cfg;
                        s_reg <= bus.cfg_sweeps;
                        sc    <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (finish) begin
                        state <= IDLE;
                    end else if (bus.cmd_stop) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (finish) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (counting && sweep_end) begin
                sc <= sc_inc;
            end
            ci        <= ci_next;
            busy_reg  <= active_next;
            start_reg <= active_next && (ci_next == '0);
            done_reg  <= finish;
        end
    end

    assign bus.start         = start_reg;
    assign bus.busy          = busy_reg;
    assign bus.done          = done_reg;
    assign bus.channel_index = ci;
    assign bus.sweep_count   = sc;

endmodule
